// File: rtl/issue_scheduler.sv
// issue_scheduler: front-end scheduler between the instruction queue and the
// reservation stations. It pops one instruction per cycle, classifies it by
// iq_inst[31:29], picks a free functional unit of that class round-robin,
// allocates the reorder-buffer tail entry and broadcasts the instruction on
// the CDB_inst lane for exactly one cycle.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   flush                 synchronous squash of held work
//   iq_valid/iq_inst      instruction queue head
//   iq_ready              head consumed this cycle (combinational)
//   busy                  per-FU busy flags (adders, mults, stores, loads, branch)
//   rb_full/rb_tail       reorder buffer status and next allocation index
//   rb_alloc              one-cycle allocate pulse
//   CDB_inst_fu/_inst/_RBindex  issue broadcast, fu all-ones when idle
//   illegal               one-cycle pulse when an unknown class is dropped
//   stall_cycles          saturating HOLD-without-issue counter
//
// Optional feature: define ISSUE_STALL_COUNT_EN to build the stall counter;
// otherwise stall_cycles is tied to zero.
module issue_scheduler #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDER_NUM  = 2,
  parameter int unsigned MULTER_NUM = 2,
  parameter int unsigned STORER_NUM = 2,
  parameter int unsigned LOADER_NUM = 3,
  parameter int unsigned FU_INDEX   = 4,
  parameter int unsigned RB_INDEX   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 iq_valid,
  input  logic [WORD_SIZE-1:0] iq_inst,
  output logic                 iq_ready,
  input  logic [ADDER_NUM+MULTER_NUM+STORER_NUM+LOADER_NUM:0] busy,
  input  logic                 rb_full,
  input  logic [RB_INDEX-1:0]  rb_tail,
  output logic                 rb_alloc,
  output logic [FU_INDEX-1:0]  CDB_inst_fu,
  output logic [WORD_SIZE-1:0] CDB_inst_inst,
  output logic [RB_INDEX-1:0]  CDB_inst_RBindex,
  output logic                 illegal,
  output logic [15:0]          stall_cycles
);

  localparam int unsigned FU_NUM   = ADDER_NUM + MULTER_NUM + STORER_NUM + LOADER_NUM + 1;
  localparam int unsigned FU_SPACE = 1 << FU_INDEX;
  localparam int unsigned MAX_AM   = (ADDER_NUM > MULTER_NUM) ? ADDER_NUM : MULTER_NUM;
  localparam int unsigned MAX_SL   = (STORER_NUM > LOADER_NUM) ? STORER_NUM : LOADER_NUM;
  localparam int unsigned MAX_N    = (MAX_AM > MAX_SL) ? MAX_AM : MAX_SL;

  localparam int unsigned BASE_ADD = 0;
  localparam int unsigned BASE_MUL = ADDER_NUM;
  localparam int unsigned BASE_STR = ADDER_NUM + MULTER_NUM;
  localparam int unsigned BASE_LD  = ADDER_NUM + MULTER_NUM + STORER_NUM;
  localparam int unsigned BASE_BR  = FU_NUM - 1;

  localparam logic [2:0] C_ADD = 3'd0;
  localparam logic [2:0] C_MUL = 3'd1;
  localparam logic [2:0] C_STR = 3'd2;
  localparam logic [2:0] C_LD  = 3'd3;
  localparam logic [2:0] C_BR  = 3'd4;

  localparam logic [FU_INDEX-1:0] FU_IDLE = '1;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t                r_state;
  logic [WORD_SIZE-1:0]  r_inst;
  logic [2:0]            r_cls;
  logic [FU_INDEX-1:0]   r_ptr [4];   // per-class offset from class base
  logic [FU_NUM-1:0]     r_resv;

  logic [2:0]            w_cls_in;
  logic                  w_legal_in;
  logic [FU_SPACE-1:0]   w_free;
  int unsigned           w_base;
  int unsigned           w_num;
  int unsigned           w_ptr_rel;
  int unsigned           w_rel;
  int unsigned           w_sel_rel;
  logic [FU_INDEX-1:0]   w_idx;
  logic [FU_INDEX-1:0]   w_sel;
  logic [FU_INDEX-1:0]   w_ptr_nxt;
  logic                  w_found;
  logic                  w_issue;

  assign w_cls_in   = iq_inst[31:29];
  assign w_legal_in = (w_cls_in <= C_BR);

  // Class window of the held instruction
  always_comb begin
    w_base    = 0;
    w_num     = 0;
    w_ptr_rel = 0;
    case (r_cls)
      C_ADD: begin w_base = BASE_ADD; w_num = ADDER_NUM;  w_ptr_rel = 32'(r_ptr[0]); end
      C_MUL: begin w_base = BASE_MUL; w_num = MULTER_NUM; w_ptr_rel = 32'(r_ptr[1]); end
      C_STR: begin w_base = BASE_STR; w_num = STORER_NUM; w_ptr_rel = 32'(r_ptr[2]); end
      C_LD:  begin w_base = BASE_LD;  w_num = LOADER_NUM; w_ptr_rel = 32'(r_ptr[3]); end
      C_BR:  begin w_base = BASE_BR;  w_num = 1;          w_ptr_rel = 0;             end
      default: ;
    endcase
  end

  // Round-robin search: first free, unreserved FU starting at the class pointer
  always_comb begin
    w_free                = '0;
    w_free[FU_NUM-1:0]    = ~busy & ~r_resv;
    w_found               = 1'b0;
    w_sel                 = '0;
    w_sel_rel             = 0;
    w_rel                 = 0;
    w_idx                 = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (!w_found && (k < w_num)) begin
        w_rel = w_ptr_rel + k;
        if (w_rel >= w_num) w_rel = w_rel - w_num;
        w_idx = FU_INDEX'(w_base + w_rel);
        if (w_free[w_idx]) begin
          w_found   = 1'b1;
          w_sel     = w_idx;
          w_sel_rel = w_rel;
        end
      end
    end
    w_ptr_nxt = (w_sel_rel + 1 >= w_num) ? '0 : FU_INDEX'(w_sel_rel + 1);
  end

  // rb_full overrides a free FU; flush suppresses issue
  assign w_issue  = (r_state == S_HOLD) && !flush && !rb_full && w_found;
  assign iq_ready = !flush && iq_valid && ((r_state == S_EMPTY) || w_issue);

  // Hold register, issue broadcast and round-robin state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_EMPTY;
      r_inst           <= '0;
      r_cls            <= '0;
      r_resv           <= '0;
      for (int i = 0; i < 4; i++) r_ptr[i] <= '0;
      rb_alloc         <= 1'b0;
      CDB_inst_fu      <= FU_IDLE;
      CDB_inst_inst    <= '0;
      CDB_inst_RBindex <= '0;
      illegal          <= 1'b0;
    end else begin
      rb_alloc         <= 1'b0;
      CDB_inst_fu      <= FU_IDLE;
      CDB_inst_inst    <= '0;
      CDB_inst_RBindex <= '0;
      illegal          <= 1'b0;
      // The issued FU's busy rises a cycle late, so block it for one cycle
      r_resv           <= '0;

      if (w_issue) begin
        rb_alloc         <= 1'b1;
        CDB_inst_fu      <= w_sel;
        CDB_inst_inst    <= r_inst;
        CDB_inst_RBindex <= rb_tail;
        r_resv           <= FU_NUM'(1) << w_sel;
        if (r_cls != C_BR) r_ptr[r_cls[1:0]] <= w_ptr_nxt;
      end

      if (flush) begin
        r_state <= S_EMPTY;
      end else if (iq_ready) begin
        illegal <= !w_legal_in;
        if (w_legal_in) begin
          r_state <= S_HOLD;
          r_inst  <= iq_inst;
          r_cls   <= w_cls_in;
        end else begin
          r_state <= S_EMPTY;
        end
      end else if (w_issue) begin
        r_state <= S_EMPTY;
      end
    end
  end

`ifdef ISSUE_STALL_COUNT_EN
  logic [15:0] r_stall;

  // Saturating count of HOLD cycles that did not issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((r_state == S_HOLD) && !w_issue && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic        iq_ready;
  logic [9:0]  busy;
  logic        rb_full;
  logic [2:0]  rb_tail;
  logic        rb_alloc;
  logic [3:0]  cdb_fu;
  logic [31:0] cdb_inst;
  logic [2:0]  cdb_rb;
  logic        illegal;
  logic [15:0] stall_cycles;

  issue_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .iq_valid         (iq_valid),
    .iq_inst          (iq_inst),
    .iq_ready         (iq_ready),
    .busy             (busy),
    .rb_full          (rb_full),
    .rb_tail          (rb_tail),
    .rb_alloc         (rb_alloc),
    .CDB_inst_fu      (cdb_fu),
    .CDB_inst_inst    (cdb_inst),
    .CDB_inst_RBindex (cdb_rb),
    .illegal          (illegal),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: FU classes as (base, count); pointer is the absolute
  // index where the next search of that class starts.
  int   cls_base [5] = '{0, 2, 4, 6, 9};
  int   cls_num  [5] = '{2, 2, 2, 3, 1};
  bit   m_held;
  logic [31:0] m_inst;
  int   m_ptr [5];
  int   m_resv;
  int   m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held  = 1'b0;
    m_inst  = '0;
    for (int i = 0; i < 5; i++) m_ptr[i] = cls_base[i];
    m_resv  = -1;
    m_stall = 0;
  endtask

  // One clock: predict from current inputs, check iq_ready, clock, check outputs
  task automatic cycle();
    int c;
    int pick;
    int idx;
    bit issue;
    bit ready;
    logic [3:0]  e_fu;
    logic [31:0] e_inst;
    logic [2:0]  e_rb;
    bit e_ill;
    #2;
    pick = -1;
    c    = int'(m_inst[31:29]);
    if (m_held) begin
      for (int k = 0; k < cls_num[c]; k++) begin
        idx = cls_base[c] + ((m_ptr[c] - cls_base[c] + k) % cls_num[c]);
        if (pick < 0 && !busy[idx] && idx != m_resv) pick = idx;
      end
    end
    issue  = m_held && !flush && !rb_full && (pick >= 0);
    ready  = !flush && iq_valid && (!m_held || issue);
    chk("iq_ready", 32'(iq_ready), 32'(ready));
    e_fu   = issue ? 4'(pick) : 4'hF;
    e_inst = issue ? m_inst : 32'h0;
    e_rb   = issue ? rb_tail : 3'd0;
    e_ill  = ready && (iq_inst[31:29] > 3'd4);
    if (m_held && !issue && m_stall < 65535) m_stall++;
    if (issue) m_ptr[c] = cls_base[c] + ((pick - cls_base[c] + 1) % cls_num[c]);
    m_resv = issue ? pick : -1;
    if (flush) m_held = 1'b0;
    else if (ready) begin
      m_held = (iq_inst[31:29] <= 3'd4);
      m_inst = iq_inst;
    end else if (issue) m_held = 1'b0;

    @(posedge clk);
    #1;
    chk("cdb_fu", 32'(cdb_fu), 32'(e_fu));
    chk("cdb_inst", cdb_inst, e_inst);
    chk("cdb_rbindex", 32'(cdb_rb), 32'(e_rb));
    chk("rb_alloc", 32'(rb_alloc), 32'(issue));
    chk("illegal", 32'(illegal), 32'(e_ill));
`ifdef ISSUE_STALL_COUNT_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`else
    chk("stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    if (issue) rb_tail = rb_tail + 3'd1;
  endtask

  task automatic drive(input bit v, input logic [31:0] inst, input logic [9:0] b,
                       input bit full, input bit fl);
    iq_valid = v;
    iq_inst  = inst;
    busy     = b;
    rb_full  = full;
    flush    = fl;
    cycle();
  endtask

  function automatic logic [31:0] mk(input int cls, input int tag);
    return {3'(cls), 29'(tag)};
  endfunction

  initial begin
    logic [31:0] rnd_inst;
    int          rnd_cls;

    reset    = 1'b1;
    flush    = 1'b0;
    iq_valid = 1'b0;
    iq_inst  = '0;
    busy     = '0;
    rb_full  = 1'b0;
    rb_tail  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fu", 32'(cdb_fu), 32'hF);
    chk("reset_inst", cdb_inst, 32'h0);
    chk("reset_rbindex", 32'(cdb_rb), 32'h0);
    chk("reset_alloc", 32'(rb_alloc), 32'h0);
    chk("reset_illegal", 32'(illegal), 32'h0);
    chk("reset_stall", 32'(stall_cycles), 32'h0);
    reset = 1'b0;
    model_reset();

    // Three adders back-to-back: FU 0,1,0 with RB 0,1,2
    drive(1, mk(0, 11), 10'h000, 0, 0);
    drive(1, mk(0, 12), 10'h000, 0, 0);
    chk("add0_fu", 32'(cdb_fu), 32'd0);
    chk("add0_rb", 32'(cdb_rb), 32'd0);
    drive(1, mk(0, 13), 10'h000, 0, 0);
    chk("add1_fu", 32'(cdb_fu), 32'd1);
    chk("add1_rb", 32'(cdb_rb), 32'd1);
    drive(0, 32'h0, 10'h000, 0, 0);
    chk("add2_fu", 32'(cdb_fu), 32'd0);
    chk("add2_rb", 32'(cdb_rb), 32'd2);

    // Multiplier blocked five cycles by busy[3:2], then FU 2 frees
    drive(1, mk(1, 21), 10'h00C, 0, 0);
    repeat (5) drive(0, 32'h0, 10'h00C, 0, 0);
    drive(0, 32'h0, 10'h008, 0, 0);
    chk("mul_fu", 32'(cdb_fu), 32'd2);
`ifdef ISSUE_STALL_COUNT_EN
    chk("mul_stall", 32'(stall_cycles), 32'd5);
`endif

    // Load held behind rb_full for three cycles, next load waits at the head
    drive(1, mk(3, 31), 10'h000, 1, 0);
    repeat (3) drive(1, mk(3, 32), 10'h000, 1, 0);
    drive(1, mk(3, 32), 10'h000, 0, 0);
    chk("ld_fu", 32'(cdb_fu), 32'd6);
    drive(0, 32'h0, 10'h000, 0, 0);
    chk("ld2_fu", 32'(cdb_fu), 32'd7);

    // Illegal class 6: consumed, pulse, no issue
    drive(1, mk(6, 41), 10'h000, 0, 0);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_fu", 32'(cdb_fu), 32'hF);
    drive(0, 32'h0, 10'h000, 0, 0);
    chk("ill_clear", 32'(illegal), 32'd0);

    // Branch flushed in the cycle it could first issue, next branch issues
    drive(1, mk(4, 51), 10'h200, 0, 0);
    drive(0, 32'h0, 10'h200, 0, 0);
    drive(0, 32'h0, 10'h000, 0, 1);
    drive(1, mk(4, 52), 10'h000, 0, 0);
    drive(0, 32'h0, 10'h000, 0, 0);
    chk("br_fu", 32'(cdb_fu), 32'd9);
    chk("br_inst", cdb_inst, mk(4, 52));

    // Async reset while an adder is held; post-reset adder goes to FU 0
    drive(1, mk(0, 61), 10'h003, 0, 0);
    drive(0, 32'h0, 10'h003, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_fu", 32'(cdb_fu), 32'hF);
    chk("areset_alloc", 32'(rb_alloc), 32'h0);
    chk("areset_stall", 32'(stall_cycles), 32'h0);
    #1;
    reset   = 1'b0;
    rb_tail = '0;
    model_reset();
    drive(1, mk(0, 62), 10'h000, 0, 0);
    drive(0, 32'h0, 10'h000, 0, 0);
    chk("post_reset_fu", 32'(cdb_fu), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rnd_cls  = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      rnd_inst = mk(rnd_cls, int'($urandom));
      drive($urandom_range(0, 3) != 0, rnd_inst, 10'($urandom) & 10'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
